exec_array: RTL and testbench

//  Parametrised N-lane multiply-accumulate execution core: successor to the 2-lane exec top.

---
 rtl/exec_array.sv | 222 ++++++++++++++++++++++
 tb/tb_exec_array.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/exec_array.sv
// exec_array: N-lane signed fixed-point multiply-accumulate core.
//
// Each lane owns an operand FIFO, which keeps every word it has accepted so
// that REWIND can replay the vector, and a weight LIFO. A RUN pops one
// operand/weight pair per lane per beat into a registered multiplier stage.
// A registered adder tree follows, and an accumulator sums the tree output.
// After the last beat, two drain cycles flush the pipeline. The DONE cycle
// then presents the saturated (or wrapped) accumulator as the result.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          synchronous reset, active low
//   cmd_valid    command present
//   cmd_ready    command accepted when cmd_valid & cmd_ready
//   cmd          0 PUSH_OP, 1 PUSH_W, 2 RUN, 3 REWIND
//   lane_mask    lanes addressed by the command
//   data_in      push data; for RUN, bit 0 = acc_keep
//   busy         FSM not idle
//   result_valid one-cycle pulse with a new result
//   result       dot-product result, held until the next result_valid
//   op_empty     per-lane operand FIFO has no unread entry
//   ovf          sticky: push to a full lane, or result out of range
module exec_array #(
   parameter int N_LANES  = 2,
   parameter int WIDTH    = 32,
   parameter int FRAC     = 16,
   parameter int DEPTH    = 16,
   parameter int SATURATE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd,
   input  logic [N_LANES-1:0] lane_mask,
   input  logic [WIDTH-1:0]   data_in,
   output logic               busy,
   output logic               result_valid,
   output logic [WIDTH-1:0]   result,
   output logic [N_LANES-1:0] op_empty,
   output logic               ovf
);
   localparam int PW = $clog2(DEPTH);          // pointer width
   localparam int CW = PW + 1;                 // count width, 0..DEPTH
   localparam int MW = WIDTH + 1;              // truncated product width
   localparam int AW = WIDTH + $clog2(N_LANES) + 8;

   localparam logic [1:0] CMD_PUSH_OP = 2'd0;
   localparam logic [1:0] CMD_PUSH_W  = 2'd1;
   localparam logic [1:0] CMD_RUN     = 2'd2;
   localparam logic [1:0] CMD_REWIND  = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                     state_q, state_d;
   logic                       drain_q, drain_d;
   logic [N_LANES-1:0]         run_mask_q, run_mask_d;
   logic [AW-1:0]              acc_q, acc_d;
   logic [AW-1:0]              tree_q, tree_sum;
   logic [WIDTH-1:0]           result_q, result_d;
   logic                       ovf_q, ovf_d;
   logic                       accept, beat;
   logic [N_LANES-1:0]         more;       // lane still has unread operands after this beat
   logic [N_LANES-1:0]         lane_ovf;
   logic [N_LANES-1:0][MW-1:0] prod_all;
   logic [AW-WIDTH:0]          acc_hi;
   logic                       acc_ovf;
   logic [WIDTH-1:0]           sat_val;

   // The DONE cycle is also ready, so a new command can be taken in the
   // same cycle as result_valid (back-to-back operation).
   assign cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE);
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state_q != S_IDLE);
   assign ovf       = ovf_q;

   for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
      logic [WIDTH-1:0]          op_mem [DEPTH];
      logic [WIDTH-1:0]          w_mem  [DEPTH];
      logic [PW-1:0]             op_wr_q, op_rd_q;
      logic [CW-1:0]             op_fill_q, op_unread_q, w_sp_q;
      logic                      push_op, push_w, rewind, pop;
      logic                      op_full, w_full, op_has, w_has;
      logic [WIDTH-1:0]          a, b;
      logic signed [2*WIDTH-1:0] full_prod;
      logic [MW-1:0]             prod_d, prod_q;

      assign push_op = accept && (cmd == CMD_PUSH_OP) && lane_mask[gi];
      assign push_w  = accept && (cmd == CMD_PUSH_W)  && lane_mask[gi];
      assign rewind  = accept && (cmd == CMD_REWIND)  && lane_mask[gi];
      assign pop     = beat && run_mask_q[gi];
      assign op_full = (op_fill_q == CW'(DEPTH));
      assign w_full  = (w_sp_q == CW'(DEPTH));
      assign op_has  = (op_unread_q != '0);
      assign w_has   = (w_sp_q != '0);

      // Empty storage feeds zero so that lane adds nothing to the beat.
      assign a = op_has ? op_mem[op_rd_q] : '0;
      assign b = w_has ? w_mem[PW'(w_sp_q - CW'(1))] : '0;

      assign full_prod = $signed(a) * $signed(b);
      assign prod_d    = pop ? MW'(full_prod >>> FRAC) : '0;

      assign more[gi]     = run_mask_q[gi] && (op_unread_q > CW'(1));
      assign lane_ovf[gi] = (push_op && op_full) || (push_w && w_full);
      assign op_empty[gi] = !op_has;
      assign prod_all[gi] = prod_q;

      // Storage is never cleared by reset.
      always_ff @(posedge clk) begin
         if (push_op && !op_full) op_mem[op_wr_q] <= data_in;
         if (push_w && !w_full) w_mem[PW'(w_sp_q)] <= data_in;
      end

      // The fill count only grows: popped operands remain retained for REWIND.
      always_ff @(posedge clk) begin
         if (!rst) begin
            op_wr_q     <= '0;
            op_rd_q     <= '0;
            op_fill_q   <= '0;
            op_unread_q <= '0;
            w_sp_q      <= '0;
            prod_q      <= '0;
         end else begin
            prod_q <= prod_d;
            if (push_op && !op_full) begin
               op_wr_q     <= op_wr_q + PW'(1);
               op_fill_q   <= op_fill_q + CW'(1);
               op_unread_q <= op_unread_q + CW'(1);
            end else if (rewind) begin
               op_rd_q     <= op_wr_q - op_fill_q[PW-1:0];
               op_unread_q <= op_fill_q;
            end else if (pop && op_has) begin
               op_rd_q     <= op_rd_q + PW'(1);
               op_unread_q <= op_unread_q - CW'(1);
            end
            if (push_w && !w_full) w_sp_q <= w_sp_q + CW'(1);
            else if (pop && w_has) w_sp_q <= w_sp_q - CW'(1);
         end
      end
   end

   // The whole adder tree is summed in a single registered stage.
   always_comb begin
      tree_sum = '0;
      for (int i = 0; i < N_LANES; i++) begin
         tree_sum = tree_sum + AW'($signed(prod_all[i]));
      end
   end

   // The result is out of range unless every bit from the result sign bit
   // upward is identical.
   assign acc_hi  = acc_q[AW-1:WIDTH-1];
   assign acc_ovf = !((&acc_hi) || !(|acc_hi));

   always_comb begin
      sat_val = acc_q[WIDTH-1:0];
      if (acc_ovf && (SATURATE != 0)) begin
         sat_val = acc_q[AW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   assign result = (state_q == S_DONE) ? sat_val : result_q;

   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      run_mask_d   = run_mask_q;
      acc_d        = acc_q + tree_q;
      result_d     = result_q;
      ovf_d        = ovf_q | (|lane_ovf);
      beat         = 1'b0;
      result_valid = 1'b0;
      case (state_q)
         S_IDLE: ;
         S_RUN: begin
            beat = 1'b1;
            if (!(|more)) begin
               state_d = S_DRAIN;
               drain_d = 1'b0;
            end
         end
         S_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) state_d = S_DONE;
         end
         S_DONE: begin
            result_valid = 1'b1;
            result_d     = sat_val;
            ovf_d        = ovf_d | acc_ovf;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // This runs after the case so that a RUN taken in DONE takes priority.
      if (accept && (cmd == CMD_RUN)) begin
         run_mask_d = lane_mask;
         acc_d      = data_in[0] ? acc_q : '0;
         state_d    = S_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         drain_q    <= 1'b0;
         run_mask_q <= '0;
         acc_q      <= '0;
         tree_q     <= '0;
         result_q   <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         drain_q    <= drain_d;
         run_mask_q <= run_mask_d;
         acc_q      <= acc_d;
         tree_q     <= tree_sum;
         result_q   <= result_d;
         ovf_q      <= ovf_d;
      end
   end
endmodule

// File: tb/tb_exec_array.sv
// tb_exec_array: directed bench for exec_array (2 lanes, 32-bit, Q16.16, depth 16).
// Two instances receive identical stimulus: dut_s saturates and dut_w wraps.
module tb_exec_array;
   localparam logic [1:0] PUSH_OP = 2'd0;
   localparam logic [1:0] PUSH_W  = 2'd1;
   localparam logic [1:0] RUN     = 2'd2;
   localparam logic [1:0] REWIND  = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd = 2'd0;
   logic [1:0]  lane_mask = 2'd0;
   logic [31:0] data_in = 32'd0;

   logic        cmd_ready_s, busy_s, rv_s, ovf_s;
   logic [31:0] result_s;
   logic [1:0]  op_empty_s;
   logic        cmd_ready_w, busy_w, rv_w, ovf_w;
   logic [31:0] result_w;
   logic [1:0]  op_empty_w;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   exec_array #(.N_LANES(2), .WIDTH(32), .FRAC(16), .DEPTH(16), .SATURATE(1)) dut_s (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_s), .cmd(cmd),
      .lane_mask(lane_mask), .data_in(data_in), .busy(busy_s), .result_valid(rv_s),
      .result(result_s), .op_empty(op_empty_s), .ovf(ovf_s)
   );

   exec_array #(.N_LANES(2), .WIDTH(32), .FRAC(16), .DEPTH(16), .SATURATE(0)) dut_w (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w), .cmd(cmd),
      .lane_mask(lane_mask), .data_in(data_in), .busy(busy_w), .result_valid(rv_w),
      .result(result_w), .op_empty(op_empty_w), .ovf(ovf_w)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a command for one cycle; the DUT is expected to be ready.
   task automatic issue(input logic [1:0] c, input logic [1:0] m, input logic [31:0] d);
      cmd_valid = 1'b1;
      cmd       = c;
      lane_mask = m;
      data_in   = d;
      step();
      cmd_valid = 1'b0;
   endtask

   // Issue RUN (handshake = cycle 0), then wait a bounded time for result_valid.
   // Check its cycle index, the number of busy cycles and both results.
   task automatic run_wait(input string tag, input logic [1:0] m, input logic keep,
                           input int exp_cyc, input logic [31:0] exp_s,
                           input logic [31:0] exp_w);
      int n;
      int nb;
      issue(RUN, m, {31'd0, keep});
      n  = 1;
      nb = 0;
      while (n < 40 && !rv_s) begin
         if (busy_s) nb++;
         step();
         n++;
      end
      if (busy_s) nb++;
      chk({tag, "_latency"}, 32'(n), 32'(exp_cyc));
      chk({tag, "_busy_cycles"}, 32'(nb), 32'(exp_cyc));
      chk({tag, "_result_sat"}, result_s, exp_s);
      chk({tag, "_result_wrap"}, result_w, exp_w);
      step();
   endtask

   initial begin
      int nrv;
      // Reset state
      rst = 1'b0;
      step();
      step();
      chk("rst_busy", 32'(busy_s), 32'd0);
      chk("rst_result_valid", 32'(rv_s), 32'd0);
      chk("rst_result", result_s, 32'd0);
      chk("rst_ovf", 32'(ovf_s), 32'd0);
      chk("rst_op_empty", 32'(op_empty_s), 32'd3);
      chk("rst_cmd_ready", 32'(cmd_ready_s), 32'd1);
      rst = 1'b1;
      step();

      // T1: 1.0*3.0 + 2.0*0.5 + 1.0*1.0 = 5.0
      issue(PUSH_OP, 2'b01, 32'h0001_0000);
      issue(PUSH_OP, 2'b01, 32'h0002_0000);
      issue(PUSH_W,  2'b01, 32'h0000_8000);
      issue(PUSH_W,  2'b01, 32'h0003_0000);
      issue(PUSH_OP, 2'b10, 32'h0001_0000);
      issue(PUSH_W,  2'b10, 32'h0001_0000);
      chk("t1_op_empty", 32'(op_empty_s), 32'd0);
      run_wait("t1", 2'b11, 1'b0, 5, 32'h0005_0000, 32'h0005_0000);
      chk("t1_busy_after", 32'(busy_s), 32'd0);
      chk("t1_result_held", result_s, 32'h0005_0000);
      chk("t1_op_empty_after", 32'(op_empty_s), 32'd3);
      chk("t1_ovf", 32'(ovf_s), 32'd0);

      // T2: replay lane0 against weights 1.0, 1.0 and keep acc: 5 + 3 = 8
      issue(REWIND, 2'b01, 32'd0);
      chk("t2_op_empty_rewind", 32'(op_empty_s), 32'd2);
      issue(PUSH_W, 2'b01, 32'h0001_0000);
      issue(PUSH_W, 2'b01, 32'h0001_0000);
      run_wait("t2", 2'b01, 1'b1, 5, 32'h0008_0000, 32'h0008_0000);

      // T5: everything empty, keep=0 clears the 8.0 in acc; one zero beat
      run_wait("t5", 2'b11, 1'b0, 4, 32'd0, 32'd0);

      // T6 setup: a nonzero result to see it cleared by reset (1.0*2.0)
      issue(PUSH_OP, 2'b01, 32'h0001_0000);
      issue(PUSH_W,  2'b01, 32'h0002_0000);
      run_wait("t6_pre", 2'b01, 1'b0, 4, 32'h0002_0000, 32'h0002_0000);

      // T6: reset during beat 2 of a 3-beat RUN
      issue(PUSH_OP, 2'b01, 32'h0001_0000);
      issue(PUSH_OP, 2'b01, 32'h0001_0000);
      issue(PUSH_OP, 2'b01, 32'h0001_0000);
      issue(PUSH_W,  2'b01, 32'h0001_0000);
      issue(RUN, 2'b01, 32'd0);   // now in beat 1
      step();                     // now in beat 2
      chk("t6_busy_beat2", 32'(busy_s), 32'd1);
      chk("t6_cmd_ready_beat2", 32'(cmd_ready_s), 32'd0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("t6_busy", 32'(busy_s), 32'd0);
      chk("t6_result_valid", 32'(rv_s), 32'd0);
      chk("t6_op_empty", 32'(op_empty_s), 32'd3);
      chk("t6_result", result_s, 32'd0);
      chk("t6_cmd_ready", 32'(cmd_ready_s), 32'd1);
      nrv = 0;
      repeat (8) begin
         if (rv_s) nrv++;
         step();
      end
      chk("t6_no_result_pulse", 32'(nrv), 32'd0);

      // T3: DEPTH+1 pushes; the 17th is dropped. Sum of raw 1..16 times 1.0 = 136.
      for (int i = 0; i < 16; i++) issue(PUSH_OP, 2'b01, 32'(i + 1));
      chk("t3_ovf_at_full", 32'(ovf_s), 32'd0);
      issue(PUSH_OP, 2'b01, 32'd17);
      chk("t3_ovf", 32'(ovf_s), 32'd1);
      chk("t3_op_empty", 32'(op_empty_s), 32'd2);
      for (int i = 0; i < 16; i++) issue(PUSH_W, 2'b01, 32'h0001_0000);
      chk("t3_ovf_w", 32'(ovf_s), 32'd1);
      run_wait("t3", 2'b01, 1'b0, 19, 32'd136, 32'd136);

      // T4: 32767.0 * 2.0 overflows Q16.16
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("t4_ovf_clear", 32'(ovf_s), 32'd0);
      issue(PUSH_OP, 2'b01, 32'h7FFF_0000);
      issue(PUSH_W,  2'b01, 32'h0002_0000);
      run_wait("t4", 2'b01, 1'b0, 4, 32'h7FFF_FFFF, 32'hFFFE_0000);
      chk("t4_ovf_sat", 32'(ovf_s), 32'd1);
      chk("t4_ovf_wrap", 32'(ovf_w), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
